// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_pkg
// Desc     : Shared types and helpers for the serial-parallel multiplier.
// Revision : 1.0
// ============================================================================
package spm_pkg;

  localparam int SPM_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_e;

  // Counter must reach 2*size, the index of the final capture edge.
  function automatic int spm_cnt_w(input int size);
    return $clog2(2 * size + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spm_mul_ctrl_if
// Desc     : Operand and product valid/ready handshakes of the multiplier.
// Revision : 1.0
// ============================================================================
interface spm_mul_ctrl_if #(
  parameter int SIZE = spm_pkg::SPM_SIZE_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   mc;
  logic [SIZE-1:0]   mp;
  logic              out_valid;
  logic              out_ready;
  logic [2*SIZE-1:0] prod;

  modport master (
    output in_valid, mc, mp, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, mc, mp, out_ready,
    output in_ready, out_valid, prod
  );

endinterface
`default_nettype wire

// File: rtl/spm_csa_chain.sv
`default_nettype none
// ============================================================================
// Module   : spm_csa_chain
// Desc     : Carry-save chain; x parallel, y serial LSB-first, product on p.
// Revision : 1.0
// ============================================================================
module spm_csa_chain
  import spm_pkg::*;
#(
  parameter int SIZE = SPM_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [SIZE-1:0] x,
  input  logic            y,
  output logic            p
);

  logic [SIZE-1:0] sum_w;

  for (genvar i = 0; i < SIZE; i++) begin : g_cell
    logic a;
    logic s_q;
    logic c_q;

    assign a        = x[i] & y;
    assign sum_w[i] = s_q;

    if (i == SIZE - 1) begin : g_tcmp
      // Serial negation of x[msb]*y: pass bits through the first 1, invert after.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s_q <= 1'b0;
          c_q <= 1'b0;
        end else if (clr) begin
          s_q <= 1'b0;
          c_q <= 1'b0;
        end else if (en) begin
          s_q <= a ^ c_q;
          c_q <= a | c_q;
        end
      end
    end else begin : g_fa
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s_q <= 1'b0;
          c_q <= 1'b0;
        end else if (clr) begin
          s_q <= 1'b0;
          c_q <= 1'b0;
        end else if (en) begin
          s_q <= a ^ sum_w[i+1] ^ c_q;
          c_q <= (a & sum_w[i+1]) | (a & c_q) | (sum_w[i+1] & c_q);
        end
      end
    end
  end

  assign p = sum_w[0];

endmodule
`default_nettype wire

// File: rtl/spm_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spm_mul_ctrl
// Desc     : Handshake/sequencing wrapper streaming operands through the chain.
// Revision : 1.0
// ============================================================================
module spm_mul_ctrl
  import spm_pkg::*;
#(
  parameter int SIZE = SPM_SIZE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  spm_mul_ctrl_if.slave  bus
);

  localparam int            CW       = spm_cnt_w(SIZE);
  localparam int            PW       = 2 * SIZE;
  localparam logic [CW-1:0] CNT_LAST = CW'(PW);

  spm_state_e      state;
  spm_state_e      state_nxt;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] x_q;
  logic [PW-1:0]   y_sr;
  logic [PW-1:0]   p_sr;
  logic [PW-1:0]   prod_q;
  logic            accept;
  logic            running;
  logic            chain_p;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign running = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)    state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (bus.out_ready)   state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      x_q    <= '0;
      y_sr   <= '0;
      p_sr   <= '0;
      prod_q <= '0;
    end else if (accept) begin
      cnt  <= '0;
      x_q  <= bus.mc;
      y_sr <= {{SIZE{bus.mp[SIZE-1]}}, bus.mp};
    end else if (running) begin
      cnt  <= cnt + CW'(1);
      y_sr <= {y_sr[PW-1], y_sr[PW-1:1]};
      // Stage-0 sum lags the counter by one: it holds bit cnt-1.
      if (cnt != '0)
        p_sr <= {chain_p, p_sr[PW-1:1]};
      if (cnt == CNT_LAST)
        prod_q <= {chain_p, p_sr[PW-1:1]};
    end
  end

  spm_csa_chain #(
    .SIZE (SIZE)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (running),
    .clr (accept),
    .x   (x_q),
    .y   (y_sr[0]),
    .p   (chain_p)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.prod      = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_spm_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_mul_ctrl
// Desc     : Directed SIZE=8 sequence plus randomised SIZE=4/16 sweeps.
// Revision : 1.0
// ============================================================================
module tb_spm_mul_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_mul_ctrl_if #(.SIZE(8))  b8 ();
  spm_mul_ctrl_if #(.SIZE(4))  b4 ();
  spm_mul_ctrl_if #(.SIZE(16)) b16 ();

  spm_mul_ctrl #(.SIZE(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  spm_mul_ctrl #(.SIZE(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4));
  spm_mul_ctrl #(.SIZE(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];
  logic [31:0] q16[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    b8.mc = a;
    b8.mp = b;
    b8.in_valid = 1'b1;
    q8.push_back(sa * sb);
    check("accept_rdy", 64'(b8.in_ready), 64'(1));
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.mc = 8'hA5;
    b8.mp = 8'h5A;
  endtask

  // Entered at the negedge after the accept edge; cyc counts edges since it.
  task automatic wait8(input string tag, input int exp_lat);
    int cyc = 0;
    bit rdy_low = 1'b1;
    while (b8.out_valid !== 1'b1 && cyc < 80) begin
      if (b8.in_ready !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_rdy_low"}, 64'(rdy_low), 64'(1));
    check({tag, "_rdy_done"}, 64'(b8.in_ready), 64'(0));
    check({tag, "_prod"}, 64'(b8.prod), 64'(q8.pop_front()));
  endtask

  task automatic release8();
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    check("rel_rdy", 64'(b8.in_ready), 64'(1));
    check("rel_vld", 64'(b8.out_valid), 64'(0));
  endtask

  task automatic sweep4(input int n);
    int sent = 0, got = 0, guard = 0;
    bit fired;
    logic signed [7:0] sa, sb;
    while (got < n && guard < 60 * n) begin
      if (!b4.in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        b4.mc = 4'($urandom);
        b4.mp = 4'($urandom);
        b4.in_valid = 1'b1;
      end
      b4.out_ready = ($urandom_range(0, 2) != 0);
      fired = b4.in_valid && b4.in_ready;
      if (fired) begin
        sa = $signed(b4.mc);
        sb = $signed(b4.mp);
        q4.push_back(sa * sb);
        sent++;
      end
      if (b4.out_valid && b4.out_ready) begin
        check("sweep4", 64'(b4.prod), 64'(q4.pop_front()));
        got++;
      end
      @(negedge clk);
      guard++;
      if (fired) b4.in_valid = 1'b0;
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b0;
    check("sweep4_count", 64'(got), 64'(n));
  endtask

  task automatic sweep16(input int n);
    int sent = 0, got = 0, guard = 0;
    bit fired;
    logic signed [31:0] sa, sb;
    while (got < n && guard < 60 * n) begin
      if (!b16.in_valid && sent < n && $urandom_range(0, 3) != 0) begin
        b16.mc = 16'($urandom);
        b16.mp = 16'($urandom);
        b16.in_valid = 1'b1;
      end
      b16.out_ready = ($urandom_range(0, 2) != 0);
      fired = b16.in_valid && b16.in_ready;
      if (fired) begin
        sa = $signed(b16.mc);
        sb = $signed(b16.mp);
        q16.push_back(sa * sb);
        sent++;
      end
      if (b16.out_valid && b16.out_ready) begin
        check("sweep16", 64'(b16.prod), 64'(q16.pop_front()));
        got++;
      end
      @(negedge clk);
      guard++;
      if (fired) b16.in_valid = 1'b0;
    end
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b0;
    check("sweep16_count", 64'(got), 64'(n));
  endtask

  initial begin
    int  t1, t2, nout;
    bit  stable;

    b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.mc = '0;  b8.mp = '0;
    b4.in_valid = 1'b0;  b4.out_ready = 1'b0;  b4.mc = '0;  b4.mp = '0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.mc = '0; b16.mp = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(b8.in_ready), 64'(1));
    check("rst_out_valid", 64'(b8.out_valid), 64'(0));
    check("rst_prod", 64'(b8.prod), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    start8(8'd3, 8'd5);     wait8("p3x5", 17);    release8();
    start8(8'hFD, 8'd5);    wait8("m3x5", 17);    release8();
    start8(8'h80, 8'h80);   wait8("m128sq", 17);  release8();
    start8(8'h7F, 8'h80);   wait8("p127xm128", 17); release8();

    // Back-pressure: DONE held, new requests ignored.
    start8(8'd3, 8'd5);
    wait8("hold", 17);
    b8.in_valid = 1'b1;
    b8.mc = 8'd9;
    b8.mp = 8'd9;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (b8.out_valid !== 1'b1 || b8.prod !== 16'h000F || b8.in_ready !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'(1));
    b8.in_valid = 1'b0;
    release8();
    check("hold_prod_kept", 64'(b8.prod), 64'h000F);

    // Back-to-back with in_valid and out_ready high.
    b8.mc = 8'd7;
    b8.mp = 8'd9;
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    q8.push_back(16'h003F);
    q8.push_back(16'h0001);
    t1 = -1;
    t2 = -1;
    nout = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        b8.mc = 8'hFF;
        b8.mp = 8'hFF;
      end
      if (c == 19) b8.in_valid = 1'b0;
      if (b8.out_valid === 1'b1) begin
        if (nout == 0) t1 = c;
        else t2 = c;
        nout++;
        check("b2b_prod", 64'(b8.prod), 64'(q8.pop_front()));
      end
    end
    b8.out_ready = 1'b0;
    check("b2b_count", 64'(nout), 64'(2));
    check("b2b_first", 64'(t1), 64'(17));
    check("b2b_gap", 64'(t2 - t1), 64'(19));

    // Asynchronous reset at RUN counter 6.
    start8(8'd5, 8'd7);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_in_ready", 64'(b8.in_ready), 64'(1));
    check("arst_out_valid", 64'(b8.out_valid), 64'(0));
    check("arst_prod", 64'(b8.prod), 64'(0));
    q8.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_no_glitch", 64'(b8.out_valid), 64'(0));
    start8(8'd2, 8'hFC);
    wait8("post_rst", 17);
    release8();

    sweep4(600);
    sweep16(600);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
